// File: rtl/i2s_tx.sv
// i2s_tx: stereo I2S serial transmitter.
//   Accepts 16-bit left/right pairs through a valid/ready handshake into a
//   single-pair holding buffer, then serializes {L, R} MSB-first with the
//   I2S one-bit delay onto bclk/lrclk/sdata.
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   leftIn, rightIn     sample pair (two's complement)
//   sampleValid         pair on leftIn/rightIn is valid
//   sampleReady         holding buffer empty (registered)
//   bclk, lrclk, sdata  serial bit clock, word select (1 = right), data
//   underrun            one-clk pulse when a frame starts with no buffered pair
// Build option:
//   I2S_TX_MUTE_ON_UNDERRUN_EN  defined: an underrun frame is all zeros and the
//                               remembered pair is cleared; undefined: an
//                               underrun frame repeats the last pair sent.
module i2s_tx #(
  parameter int DATA_W   = 16,
  parameter int BCLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] leftIn,
  input  logic [DATA_W-1:0] rightIn,
  input  logic              sampleValid,
  output logic              sampleReady,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              underrun
);
  localparam int FW = 2 * DATA_W;
  localparam int DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(FW);

  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic [FW-1:0] shreg, buf_frame, last_frame, und_frame, load_frame;
  logic          full, div_wrap, fall, load, xfer;

  assign div_wrap = (div_cnt == DW'(BCLK_DIV - 1));
  // bclk is about to toggle 1 -> 0 on this edge
  assign fall     = div_wrap && bclk;
  assign bit_nxt  = (bit_cnt == BW'(FW - 1)) ? '0 : bit_cnt + BW'(1);
  // Entering slot 1 is where a new frame's MSB goes out (one-bit delay)
  assign load     = fall && (bit_nxt == BW'(1));
  assign sampleReady = !full;
  assign xfer     = sampleValid && sampleReady;

`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
  assign und_frame = '0;
`else
  assign und_frame = last_frame;
`endif
  assign load_frame = full ? buf_frame : und_frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      bit_cnt    <= BW'(FW - 1);
      bclk       <= 1'b0;
      lrclk      <= 1'b1;
      sdata      <= 1'b0;
      underrun   <= 1'b0;
      shreg      <= '0;
      buf_frame  <= '0;
      last_frame <= '0;
      full       <= 1'b0;
    end else begin
      div_cnt  <= div_wrap ? '0 : div_cnt + DW'(1);
      if (div_wrap) bclk <= ~bclk;
      underrun <= load && !full;

      if (fall) begin
        bit_cnt <= bit_nxt;
        lrclk   <= (bit_nxt >= BW'(DATA_W));
        if (load) begin
          sdata      <= load_frame[FW-1];
          shreg      <= {load_frame[FW-2:0], 1'b0};
          last_frame <= load_frame;
        end else begin
          // slot 0 shifts out the final R LSB of the frame just sent
          sdata <= shreg[FW-1];
          shreg <= {shreg[FW-2:0], 1'b0};
        end
      end

      // A load in the same clk as a transfer only ever sees an empty buffer,
      // so the new pair waits for the next frame.
      if (xfer) begin
        full      <= 1'b1;
        buf_frame <= {leftIn, rightIn};
      end else if (load && full) begin
        full <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx.sv
module tb_i2s_tx;
  localparam int W = 16;
  localparam int D = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  leftIn = '0, rightIn = '0;
  logic          sampleValid = 1'b0;
  logic          sampleReady, bclk, lrclk, sdata, underrun;

  int tests = 0, fails = 0;

  i2s_tx #(.DATA_W(W), .BCLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .leftIn(leftIn), .rightIn(rightIn),
    .sampleValid(sampleValid), .sampleReady(sampleReady),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Everything is derived from the clk edge count since reset release:
  // bclk toggles every D edges, a fall every 2*D edges enters the next slot,
  // a load happens on the fall entering slot 1.
  int          n = 0;
  logic        m_full = 0;
  logic [31:0] m_frame = 0, cur = 0;
  logic        m_und = 0;

  always @(posedge clk) begin
    int f, slot;
    logic xv, ld;
    logic e_bclk, e_lr, e_sd;
    if (!rst_n) begin
      n = 0; m_full = 0; m_frame = 0; cur = 0; m_und = 0;
    end else begin
      xv = sampleValid && !m_full;
      n++;
      f  = n / (2 * D);
      ld = (n % (2 * D) == 0) && (f >= 1) && ((f - 1) % 32 == 1);
      m_und = 0;
      if (ld) begin
        if (m_full) begin
          cur = m_frame; m_full = 0;
        end else begin
          m_und = 1;
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
          cur = 0;
`endif
        end
      end
      if (xv) begin
        m_full = 1; m_frame = {leftIn, rightIn};
      end
    end
    #1;
    if (!rst_n || n == 0) begin
      e_bclk = 0; e_lr = 1; e_sd = 0;
    end else begin
      f = n / (2 * D);
      e_bclk = ((n / D) % 2) == 1;
      if (f == 0) begin
        e_lr = 1; e_sd = 0;
      end else begin
        slot = (f - 1) % 32;
        e_lr = slot >= W;
        e_sd = (slot == 0) ? cur[0] : cur[32 - slot];
      end
    end
    chk("bclk", 32'(bclk), 32'(e_bclk));
    chk("lrclk", 32'(lrclk), 32'(e_lr));
    chk("sdata", 32'(sdata), 32'(e_sd));
    chk("sampleReady", 32'(sampleReady), 32'(!m_full));
    chk("underrun", 32'(underrun), 32'(m_und));
  end

  // ---------------- DUT-side observers for literal checks ----------------
  // Frames as the DAC sees them: sdata sampled on bclk rise, a frame is
  // complete at the first slot-0 rise (lrclk 1 -> 0).
  logic [31:0] fq[$];
  logic [31:0] cap;
  logic        plr;
  always @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      cap = 0; plr = 1;
    end else begin
      cap = {cap[30:0], sdata};
      if (plr && !lrclk) fq.push_back(cap);
      plr = lrclk;
    end
  end

  int ucount = 0;
  always @(negedge clk) if (rst_n && underrun) ucount++;

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_reset(input int k);
    rst_n = 0; sampleValid = 0;
    tick(k);
    rst_n = 1;
    fq.delete();
    ucount = 0;
  endtask

  task automatic first_fall(input string nm);
    int  c = 0;
    logic p = bclk;
    while (c < 20) begin
      tick(1); c++;
      if (p && !bclk) break;
      p = bclk;
    end
    chk(nm, 32'(c), 32'd4);
    chk({nm, "_lrclk"}, 32'(lrclk), 32'd0);
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    int t = 0;
    while (!sampleReady && t < 400) begin tick(1); t++; end
    if (!sampleReady) chk("send_timeout", 32'(t), 32'd0);
    leftIn = l; rightIn = r; sampleValid = 1;
    tick(1);
    sampleValid = 0;
  endtask

  task automatic wait_frames(input int k);
    int t = 0;
    while (fq.size() < k && t < 2000) begin tick(1); t++; end
    if (fq.size() < k) chk("frame_timeout", 32'(fq.size()), 32'(k));
  endtask

  logic [31:0] hold2;

  initial begin
    // reset defaults
    rst_n = 0;
    tick(10);
    chk("rst_bclk", 32'(bclk), 32'd0);
    chk("rst_lrclk", 32'(lrclk), 32'd1);
    chk("rst_sdata", 32'(sdata), 32'd0);
    chk("rst_ready", 32'(sampleReady), 32'd1);
    rst_n = 1; fq.delete(); ucount = 0;
    first_fall("first_fall");

    // single pair, then underrun
    send(16'hA5C3, 16'h0F0F);
    wait_frames(3);
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
    hold2 = 32'h0;
`else
    hold2 = 32'hA5C3_0F0F;
`endif
    if (fq.size() >= 3) begin
      chk("single_frame", fq[1], 32'hA5C3_0F0F);
      chk("underrun_frame", fq[2], hold2);
    end
    chk("underrun_count", 32'(ucount), 32'd1);

    // back-to-back
    do_reset(3);
    for (int i = 0; i < 4; i++) send(16'h8000, 16'h7FFF);
    send(16'h0001, 16'hFFFF);
    wait_frames(6);
    chk("b2b_underruns", 32'(ucount), 32'd0);
    if (fq.size() >= 6) begin
      for (int i = 1; i <= 4; i++) chk("b2b_frame", fq[i], 32'h8000_7FFF);
      chk("b2b_last", fq[5], 32'h0001_FFFF);
    end

    // race: valid only in the clk of load 2 (edge 136) with buffer empty
    do_reset(3);
    tick(135);
    leftIn = 16'h00FF; rightIn = 16'hC3A5; sampleValid = 1;
    tick(1);
    sampleValid = 0;
    chk("race_underrun", 32'(underrun), 32'd1);
    chk("race_ready", 32'(sampleReady), 32'd0);
    wait_frames(4);
    chk("race_ucount", 32'(ucount), 32'd2);
    if (fq.size() >= 4) begin
      chk("race_f1", fq[1], 32'h0);
      chk("race_f3", fq[3], 32'h00FF_C3A5);
    end

    // mid-frame reset at slot 9 with a pair buffered
    do_reset(3);
    tick(1);
    send(16'h1111, 16'h2222);
    send(16'h3333, 16'h4444);
    while (n < 41) tick(1);
    chk("pre_rst_ready", 32'(sampleReady), 32'd0);
    rst_n = 0;
    #1;
    chk("mid_rst_bclk", 32'(bclk), 32'd0);
    chk("mid_rst_lrclk", 32'(lrclk), 32'd1);
    chk("mid_rst_sdata", 32'(sdata), 32'd0);
    chk("mid_rst_ready", 32'(sampleReady), 32'd1);
    tick(3);
    rst_n = 1; fq.delete(); ucount = 0;
    first_fall("restart_fall");
    wait_frames(3);
    if (fq.size() >= 3) begin
      chk("restart_f1", fq[1], 32'h0);
      chk("restart_f2", fq[2], 32'h0);
    end
    chk("restart_ucount", 32'(ucount), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/i2s_tx.md
# i2s_tx

Stereo I2S serial transmitter for the channel-strip output path. Accepts parallel 16-bit left/right sample pairs from the filter chain, such as the lowpass stage, through a valid/ready handshake. Serializes them MSB-first onto a bit clock, word-select and data line for the output DAC. A single-pair holding buffer decouples the filter's sample timing from the serial frame timing.

## Interface
- DATA_W, 16, bits per channel sample and bit slots per channel; two's complement
- BCLK_DIV, 2, clk cycles per bclk half-period; legal values are 2 and above
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- leftIn  in  DATA_W  left sample
- rightIn  in  DATA_W  right sample
- sampleValid  in  1  leftIn/rightIn carry a valid pair
- sampleReady  out  1  holding buffer empty; the pair transfers on a clk edge where sampleValid && sampleReady
- bclk  out  1  serial bit clock; DAC samples sdata on bclk rising
- lrclk  out  1  word select; 0 = left, 1 = right
- sdata  out  1  serial data, MSB first, with I2S one-bit delay
- underrun  out  1  one-clk pulse when a frame starts with the holding buffer empty

## Operation
- Divider divCnt counts 0..BCLK_DIV-1. When divCnt == BCLK_DIV-1, it wraps to 0 and bclk toggles.
- A "fall" is a clk edge where bclk goes 1->0. Only falls update bitCnt, lrclk and sdata.
- bitCnt counts slots 0..2*DATA_W-1 and wraps. Each fall advances bitCnt.
- lrclk = 1 iff the new slot is in DATA_W..2*DATA_W-1.
- Frame word = {L, R}, 2*DATA_W bits, MSB first. Slot k drives frame bit k-1. Slot 0 drives the LSB of the previous R.
- Load event: the fall entering slot 1.
  - If the buffer is full, the frame is taken from the buffer, the buffer empties, and sdata = L[DATA_W-1].
  - If the buffer is empty, underrun pulses for exactly that clk and the frame is the underrun frame (see Configuration).
- Holding buffer: a transfer sets it full and captures leftIn/rightIn. sampleReady = !full, registered.
- Simultaneous transfer and load in the same clk, buffer empty beforehand: the load sees empty, underrun pulses, and the new pair stays buffered for the next frame.
- Transfer while full is impossible because ready = 0. Valid without ready is ignored; no data is lost or duplicated.

## Timing
- Reset values: bclk = 0, lrclk = 1, sdata = 0, underrun = 0, sampleReady = 1, divCnt = 0, bitCnt = 2*DATA_W-1, buffer empty, last pair = 0.
- After rst_n deasserts:
  - the first rise is at clk edge BCLK_DIV;
  - the first fall is at edge 2*BCLK_DIV, entering slot 0 with lrclk = 0;
  - the first load is at edge 4*BCLK_DIV.
- Frame period = 2*DATA_W*2*BCLK_DIV clk cycles, which is 128 at the defaults.
- sampleReady falls 1 clk after a transfer. It rises 1 clk after the load that empties the buffer.
- Latency: a pair buffered before load N has its L MSB on sdata from load N's fall.
- Reset mid-frame: all state returns to reset values immediately, asynchronously. A partial frame is abandoned and the buffered pair is discarded.

## Configuration
- I2S_TX_MUTE_ON_UNDERRUN_EN
  - Defined: the underrun frame is all zeros, and the last pair is also cleared to 0.
  - Undefined: the underrun frame repeats the last transmitted pair (hold), which is 0 after reset.
- underrun pulses in both builds.

## Test plan
- Reset: hold rst_n = 0 for 10 clk, defaults -> bclk = 0, lrclk = 1, sdata = 0, sampleReady = 1. First fall at clk 4 after release, lrclk 0 there. bclk period = 4 clk.
- Single pair: transfer L = 16'hA5C3, R = 16'h0F0F before the first load -> sdata over slots 1..32 reads A5C3 then 0F0F MSB first. lrclk rises at slot 16. sampleReady returns to 1 one clk after the load.
- Back-to-back: supply a new pair each time ready rises, 4 frames of L = 16'h8000/R = 16'h7FFF, then L = 16'h0001/R = 16'hFFFF -> every frame is correct and underrun never pulses.
- Underrun: one pair 16'h1234/16'h5678, then no valid -> second frame underrun pulse of 1 clk. sdata is all zeros if I2S_TX_MUTE_ON_UNDERRUN_EN is defined, else 1234/5678 repeated.
- Race: assert valid with L = 16'h00FF only in the clk of a load with the buffer empty -> underrun pulses, and 00FF is sent in the following frame.
- Mid-frame reset: pulse rst_n low at slot 9 for 3 clk, then release -> outputs return to reset values immediately, the buffer is empty, and the frame restarts with slot 0 at clk 4 after release.
